// File: rtl/seven_seg_if.sv
// Display-side bundle for seven_seg_scan_driver: digit/DP inputs, enable, and
// the scanned segment/digit-enable/frame outputs.
interface seven_seg_if #(
   parameter int DIGITS = 4
);
   logic                  enable;
   logic [4*DIGITS-1:0]   bcd;
   logic [DIGITS-1:0]     dp_in;
   logic [6:0]            seg;
   logic                  dp;
   logic [DIGITS-1:0]     digit_en;
   logic                  frame;

   modport master (output enable, bcd, dp_in, input seg, dp, digit_en, frame);
   modport slave  (input enable, bcd, dp_in, output seg, dp, digit_en, frame);
endinterface

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed multi-digit 7-segment scan driver with tear-free frame snapshot.
// Optional: define LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 never blanked).
module seven_seg_digit (
   input  logic [3:0] bcd,
   input  logic       blank,
   output logic [6:0] seg
);
   always_comb begin
      seg = 7'h00;
      if (!blank) begin
         case (bcd)
            4'd0:    seg = 7'h7E;
            4'd1:    seg = 7'h30;
            4'd2:    seg = 7'h6D;
            4'd3:    seg = 7'h79;
            4'd4:    seg = 7'h33;
            4'd5:    seg = 7'h5B;
            4'd6:    seg = 7'h5F;
            4'd7:    seg = 7'h72;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h7B;
            default: seg = 7'h00;
         endcase
      end
   end
endmodule

module seven_seg_scan_driver #(
   parameter int DIGITS   = 4,
   parameter int SCAN_DIV = 50000
) (
   input  logic        clk,
   input  logic        rst,
   seven_seg_if.slave  bus
);
   localparam int CW = $clog2(SCAN_DIV);
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic [CW-1:0]                cnt;
   logic [IW-1:0]                idx;
   logic [4*DIGITS-1:0]          bcd_s;
   logic [DIGITS-1:0]            dp_s;
   logic                         prime;
   logic [6:0]                   seg_r;
   logic                         dp_r;
   logic [DIGITS-1:0]            digit_en_r;
   logic                         frame_r;
   logic [DIGITS-1:0]            blank;
   logic [DIGITS-1:0][6:0]       dec;

   logic tick, last, load;
   assign tick = bus.enable && (cnt == CW'(SCAN_DIV - 1));
   assign last = (idx == IW'(DIGITS - 1));
   // Snapshot on frame wrap, or on the first enabled edge after reset.
   assign load = bus.enable && (prime || (tick && last));

   genvar i;
   generate
      for (i = 0; i < DIGITS; i++) begin : g_dig
         if (i == 0) begin : g_lsd
            assign blank[i] = 1'b0;
         end else begin : g_upper
`ifdef LEADING_ZERO_BLANK_EN
            // Blank only when this digit and everything above it is zero.
            assign blank[i] = (bcd_s[4*DIGITS-1:4*i] == '0);
`else
            assign blank[i] = 1'b0;
`endif
         end
         seven_seg_digit u_dig (
            .bcd   (bcd_s[4*i +: 4]),
            .blank (blank[i]),
            .seg   (dec[i])
         );
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt        <= '0;
         idx        <= '0;
         bcd_s      <= '0;
         dp_s       <= '0;
         prime      <= 1'b1;
         seg_r      <= '0;
         dp_r       <= 1'b0;
         digit_en_r <= '0;
         frame_r    <= 1'b0;
      end else if (bus.enable) begin
         cnt <= tick ? '0 : cnt + 1'b1;
         if (tick)
            idx <= last ? '0 : idx + 1'b1;
         if (load) begin
            bcd_s <= bus.bcd;
            dp_s  <= bus.dp_in;
            prime <= 1'b0;
         end
         frame_r    <= load;
         digit_en_r <= DIGITS'(1) << idx;
         seg_r      <= dec[idx];
         dp_r       <= dp_s[idx];
      end else begin
         // Frozen: counters and snapshot hold, display goes dark.
         frame_r    <= 1'b0;
         digit_en_r <= '0;
         seg_r      <= '0;
         dp_r       <= 1'b0;
      end
   end

   assign bus.seg      = seg_r;
   assign bus.dp       = dp_r;
   assign bus.digit_en = digit_en_r;
   assign bus.frame    = frame_r;
endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Randomized bench for seven_seg_scan_driver against a counting model of the scan.
module tb_seven_seg_scan_driver;
   localparam int DIGITS   = 4;
   localparam int SCAN_DIV = 4;
   localparam int FLEN     = DIGITS * SCAN_DIV;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;
   bit   cmp_on = 1'b0;

   seven_seg_if #(.DIGITS(DIGITS)) bus ();

   seven_seg_scan_driver #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] seg_of(input int d);
      case (d)
         0: return 7'h7E;  1: return 7'h30;  2: return 7'h6D;  3: return 7'h79;
         4: return 7'h33;  5: return 7'h5B;  6: return 7'h5F;  7: return 7'h72;
         8: return 7'h7F;  9: return 7'h7B;
         default: return 7'h00;
      endcase
   endfunction

   // Expected segments for digit i of a snapshot value.
   function automatic logic [6:0] ref_seg(input logic [4*DIGITS-1:0] s, input int i);
      logic [4*DIGITS-1:0] up;
      up = s >> (4 * i);
`ifdef LEADING_ZERO_BLANK_EN
      if (i > 0 && up == 0) return 7'h00;
`endif
      return seg_of(int'(up & 4'hF));
   endfunction

   // Model state: k = number of enabled edges since reset determines everything.
   int                  k;
   logic [4*DIGITS-1:0] snap;
   logic [DIGITS-1:0]   snap_dp;
   logic [6:0]          exp_seg;
   logic                exp_dp, exp_frame;
   logic [DIGITS-1:0]   exp_de;

   function automatic int m_idx(input int kk);
      return (kk / SCAN_DIV) % DIGITS;
   endfunction

   function automatic bit m_load(input int kk);
      return (kk == 0) || (kk % FLEN == FLEN - 1);
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         k <= 0; snap <= '0; snap_dp <= '0;
         exp_seg <= '0; exp_dp <= 1'b0; exp_frame <= 1'b0; exp_de <= '0;
      end else if (bus.enable) begin
         exp_de    <= DIGITS'(1) << m_idx(k);
         exp_seg   <= ref_seg(snap, m_idx(k));
         exp_dp    <= snap_dp[m_idx(k)];
         exp_frame <= m_load(k);
         if (m_load(k)) begin
            snap    <= bus.bcd;
            snap_dp <= bus.dp_in;
         end
         k <= k + 1;
      end else begin
         exp_seg <= '0; exp_dp <= 1'b0; exp_frame <= 1'b0; exp_de <= '0;
      end
   end

   always @(negedge clk) begin
      if (cmp_on && !rst) begin
         checks++;
         if ({bus.seg, bus.dp, bus.digit_en, bus.frame} !== {exp_seg, exp_dp, exp_de, exp_frame}) begin
            errors++;
            $display("FAIL model t=%0t seg=%h dp=%b en=%b fr=%b, want seg=%h dp=%b en=%b fr=%b",
                     $time, bus.seg, bus.dp, bus.digit_en, bus.frame, exp_seg, exp_dp, exp_de, exp_frame);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, want);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic rand_phase(input int n);
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         bus.enable = ($urandom % 8) != 0;
         if ($urandom % 6 == 0) begin
            for (int d = 0; d < DIGITS; d++)
               bus.bcd[4*d +: 4] = ($urandom % 3 == 0) ? 4'h0 : 4'($urandom % 16);
            bus.dp_in = DIGITS'($urandom);
         end
      end
   endtask

   int  zd0, zd1;
   bit  seen;

   initial begin
      bus.enable = 1'b0; bus.bcd = 16'h1234; bus.dp_in = '0;
      #1 rst = 1'b1;
      step(2);
      chk("rst_seg", 32'(bus.seg), 0);
      chk("rst_en", 32'(bus.digit_en), 0);
      chk("rst_dp_frame", {bus.dp, bus.frame}, 0);
      rst = 1'b0; cmp_on = 1'b1;
      @(negedge clk);
      bus.enable = 1'b1;
      step(1);  chk("prime_frame", 32'(bus.frame), 1); chk("prime_en", 32'(bus.digit_en), 4'b0001);
      step(1);  chk("d0_1234", 32'(bus.seg), 7'h33);
      step(4);  chk("d1_1234", 32'(bus.seg), 7'h79); chk("d1_en", 32'(bus.digit_en), 4'b0010);
      bus.bcd = 16'h5678;
      step(4);  chk("d2_torn", 32'(bus.seg), 7'h6D);
      step(4);  chk("d3_torn", 32'(bus.seg), 7'h30); chk("d3_en", 32'(bus.digit_en), 4'b1000);
      step(2);  chk("wrap_frame", 32'(bus.frame), 1);
      step(1);  chk("d0_5678", 32'(bus.seg), 7'h7F);
      step(4);  chk("d1_5678", 32'(bus.seg), 7'h72);
      step(4);  chk("d2_5678", 32'(bus.seg), 7'h5F);
      bus.bcd = 16'hFA09; bus.dp_in = 4'b0010;
      step(4);  chk("d3_5678", 32'(bus.seg), 7'h5B);
      step(4);  chk("d0_fa09", {bus.seg, bus.dp}, {7'h7B, 1'b0});
      step(4);  chk("d1_fa09", {bus.seg, bus.dp}, {7'h7E, 1'b1});
      step(4);  chk("d2_fa09", 32'(bus.seg), 7'h00);
      step(4);  chk("d3_fa09", 32'(bus.seg), 7'h00);
      // Drop enable in the second cycle of digit 1 for 10 edges.
      step(9);
      bus.enable = 1'b0;
      step(1);  chk("dis_dark", {bus.seg, bus.dp, bus.digit_en, bus.frame}, 0);
      step(9);
      bus.enable = 1'b1;
      step(1);  chk("resume_a", 32'(bus.digit_en), 4'b0010);
      step(1);  chk("resume_b", 32'(bus.digit_en), 4'b0010);
      step(1);  chk("resume_c", 32'(bus.digit_en), 4'b0100);
      // All-zero frame: digit 0 always shows zero; digit 1 depends on blanking.
      bus.bcd = 16'h0000;
      seen = 1'b0; zd0 = 0; zd1 = 0;
      for (int c = 0; c < 3 * FLEN; c++) begin
         step(1);
         if (bus.frame) seen = 1'b1;
         else if (seen && bus.digit_en == 4'b0001 && zd0 == 0) begin
            zd0 = 1; chk("zero_d0", 32'(bus.seg), 7'h7E);
         end else if (seen && bus.digit_en == 4'b0010 && zd1 == 0) begin
            zd1 = 1;
`ifdef LEADING_ZERO_BLANK_EN
            chk("zero_d1", 32'(bus.seg), 7'h00);
`else
            chk("zero_d1", 32'(bus.seg), 7'h7E);
`endif
         end
      end
      chk("zero_seen", {zd0[0], zd1[0]}, 2'b11);
      rand_phase(1500);
      // Asynchronous reset between edges.
      @(posedge clk);
      #2 rst = 1'b1;
      #1 chk("async_rst", {bus.seg, bus.dp, bus.digit_en, bus.frame}, 0);
      #1 rst = 1'b0;
      @(negedge clk);
      bus.enable = 1'b1; bus.bcd = 16'h0040;
      step(1);  chk("rst_prime_frame", 32'(bus.frame), 1); chk("rst_prime_en", 32'(bus.digit_en), 4'b0001);
      step(1);  chk("d0_0040", 32'(bus.seg), 7'h7E);
      step(4);  chk("d1_0040", 32'(bus.seg), 7'h33);
      rand_phase(1500);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
